// File: rtl/step_ctrl.sv
// step_ctrl: multi-button step controller.
//   One shared sample-tick generator drives per-button 2-FF synchronizers,
//   debouncers and auto-repeat FSMs. Press/repeat events are held in a
//   one-bit-per-button pending register. A fixed-priority arbiter (lowest
//   index first) grants one event per clock as a one-cycle step pulse.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_in       raw asynchronous button inputs (1 = pressed)
//   repeat_en    per-button auto-repeat enable
//   btn_level    debounced button levels
//   step_pulse   one-hot, one-cycle grant pulse
//   pulse_valid  high while step_pulse is nonzero
//   pulse_id     index of the granted button, 0 when pulse_valid is low
//   tick         one-cycle sample strobe
module step_ctrl #(
  parameter int N           = 4,
  parameter int DIV         = 200000,
  parameter int STABLE      = 4,
  parameter int REPEAT_DLY  = 250,
  parameter int REPEAT_RATE = 50,
  parameter int IW          = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  btn_in,
  input  logic [N-1:0]  repeat_en,
  output logic [N-1:0]  btn_level,
  output logic [N-1:0]  step_pulse,
  output logic          pulse_valid,
  output logic [IW-1:0] pulse_id,
  output logic          tick
);

  localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW   = $clog2(STABLE + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [TW-1:0] TMAX    = TW'(DIV - 1);
  localparam logic [CW-1:0] CMAX    = CW'(STABLE - 1);
  localparam logic [RW-1:0] DLY_M1  = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RATE_M1 = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  // Tick generator
  logic [TW-1:0] r_tcnt;
  logic          w_tick;

  assign w_tick = (r_tcnt == TMAX);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (reset)       r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else             r_tcnt <= r_tcnt + 1'b1;
  end

  // Synchronizer and debounce
  logic [N-1:0]  r_sync1, r_sync2, r_level;
  logic [CW-1:0] r_dcnt [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int i = 0; i < N; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        for (int i = 0; i < N; i++) begin
          // Any agreeing tick restarts the count, so glitches shorter than
          // STABLE ticks never reach btn_level.
          if (r_sync2[i] == r_level[i]) begin
            r_dcnt[i] <= '0;
          end else if (r_dcnt[i] == CMAX) begin
            r_level[i] <= r_sync2[i];
            r_dcnt[i]  <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign btn_level = r_level;

  // Repeat FSMs: state register
  state_t        r_state [N];
  state_t        w_state_nxt [N];
  logic [RW-1:0] r_rcnt [N];
  logic [RW-1:0] w_rcnt_nxt [N];
  logic [N-1:0]  w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= S_IDLE;
        r_rcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_rcnt[i]  <= w_rcnt_nxt[i];
      end
    end
  end

  // Repeat FSMs: next state. A low level forces IDLE from any state, so an
  // IDLE FSM seeing a high level is exactly a rising edge of btn_level.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_rcnt_nxt[i]  = r_rcnt[i];
      if (!r_level[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_rcnt_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            w_state_nxt[i] = S_HOLD;
            w_rcnt_nxt[i]  = '0;
          end
          S_HOLD: begin
            // rcnt parks at DLY_M1 while repeat is disabled, so re-enabling
            // fires on the very next tick.
            if (w_tick) begin
              if (r_rcnt[i] == DLY_M1) begin
                if (repeat_en[i]) begin
                  w_state_nxt[i] = S_REPEAT;
                  w_rcnt_nxt[i]  = '0;
                end
              end else begin
                w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
              end
            end
          end
          S_REPEAT: begin
            if (!repeat_en[i]) begin
              w_state_nxt[i] = S_HOLD;
              w_rcnt_nxt[i]  = DLY_M1;
            end else if (w_tick) begin
              if (r_rcnt[i] == RATE_M1) w_rcnt_nxt[i] = '0;
              else                      w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
            end
          end
          default: begin
            w_state_nxt[i] = S_IDLE;
            w_rcnt_nxt[i]  = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSMs: event outputs
  always_comb begin
    w_set = '0;
    for (int i = 0; i < N; i++) begin
      if (r_level[i]) begin
        case (r_state[i])
          S_IDLE:   w_set[i] = 1'b1;
          S_HOLD:   w_set[i] = w_tick && repeat_en[i] && (r_rcnt[i] == DLY_M1);
          S_REPEAT: w_set[i] = w_tick && repeat_en[i] && (r_rcnt[i] == RATE_M1);
          default:  w_set[i] = 1'b0;
        endcase
      end
    end
  end

  // Pending register and lowest-index-first arbiter
  logic [N-1:0]  r_pend, w_grant;
  logic [IW-1:0] w_id;
  logic [N-1:0]  r_step;
  logic          r_valid;
  logic [IW-1:0] r_id;

  // Isolate the lowest set bit.
  assign w_grant = r_pend & (~r_pend + 1'b1);

  always_comb begin
    w_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (r_pend[k]) w_id = IW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_step  <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else begin
      // Set is OR-ed after the clear so a same-cycle new event is kept.
      r_pend  <= (r_pend & ~w_grant) | w_set;
      r_step  <= w_grant;
      r_valid <= |r_pend;
      r_id    <= w_id;
    end
  end

  assign step_pulse  = r_step;
  assign pulse_valid = r_valid;
  assign pulse_id    = r_id;

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
Multi-button step controller that shares one sample-tick generator and one output channel among N board buttons. Each button gets per-button debounce and optional auto-repeat. All press/repeat events are queued as pending requests and granted one per clock, lowest index first, as single-cycle step pulses. Sits between the raw board buttons and the datapath step/load inputs. It replaces one clock-divider/debounce pair per button.

Parameters:
N, 4, number of buttons (2..8)
DIV, 200000, clk cycles per sample tick (500 Hz at 100 MHz)
STABLE, 4, consecutive differing ticks required to accept a new level
REPEAT_DLY, 250, ticks held before the first auto-repeat
REPEAT_RATE, 50, ticks between subsequent auto-repeats
IW, 2, width of pulse_id; equals clog2(N)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_in  in  N  raw asynchronous button inputs, 1 = pressed
repeat_en  in  N  per-button auto-repeat enable
btn_level  out  N  debounced button levels
step_pulse  out  N  one-hot, one-cycle grant pulse
pulse_valid  out  1  high when step_pulse is nonzero
pulse_id  out  IW  index of the granted button; 0 when pulse_valid is low
tick  out  1  one-cycle sample strobe, exported for other users

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. On reset:
  - tick counter = 0
  - all outputs = 0
  - synchronizers, debounce counters and pending = 0
  - all repeat FSMs in IDLE
- Tick generator:
  - Counter runs 0..DIV-1.
  - tick = 1 for the single cycle in which counter == DIV-1; counter then wraps to 0.
- Synchronizer: 2-FF synchronizer per bit of btn_in. The debounce logic uses only the synchronized value.
- Debounce, per button i, evaluated only on tick:
  - sync == btn_level[i]: count = 0.
  - Otherwise count increments.
  - When the count reaches STABLE-1 while differing: btn_level[i] <= sync and count = 0.
  - Net effect: a new level is accepted on the STABLE-th consecutive differing tick.
  - A single agreeing tick restarts the count (glitch rejection).
- Repeat FSM per button, states IDLE, HOLD, REPEAT, with counter rcnt:
  - IDLE -> HOLD on btn_level rising. Sets pending[i]; rcnt = 0.
  - HOLD, on each tick: rcnt++.
    - If rcnt == REPEAT_DLY-1 and repeat_en[i]: set pending[i], rcnt = 0, go to REPEAT.
    - If repeat_en[i] is low: saturate rcnt at REPEAT_DLY-1 and stay in HOLD.
  - REPEAT, on each tick: rcnt++. At REPEAT_RATE-1: set pending[i], rcnt = 0.
  - If repeat_en[i] drops while in REPEAT: return to HOLD with rcnt held at REPEAT_DLY-1. No further events until re-enabled; re-enabling then repeats on the next tick.
  - btn_level falling, from any state -> IDLE with rcnt = 0. No event on release.
- Arbiter:
  - Each clk, if pending != 0: select the lowest set index k.
  - Register step_pulse = (1<<k), pulse_valid = 1, pulse_id = k, and clear pending[k] in the same edge.
  - Otherwise all three outputs are 0 on the next cycle.
- Latency: a pending bit set at edge t with no lower-index contention produces a pulse in the cycle after edge t+1.
- Simultaneous set and clear of the same pending bit: the set wins, so no event is lost.
- Capacity: pending holds one event per button. A second event for the same button before service coalesces into one (unreachable in practice, since DIV ≥ N).
- Starvation: none. With all N pending, the grants complete in N consecutive cycles.
- Reset mid-hold or mid-queue: pending events are discarded and btn_level returns to 0. A button still held after reset releases is re-debounced and produces a fresh press event.

Test Plan:
Bench parameters: DIV=4, STABLE=3, REPEAT_DLY=5, REPEAT_RATE=2, N=4.
1. Tick and reset: release reset -> tick high every 4th cycle, first at cycle 4 after reset. All outputs 0 until then.
2. Clean press: btn_in=0001 held -> btn_level[0] rises on the 3rd tick after sync. Exactly one pulse follows with step_pulse=0001, pulse_id=0, 1 cycle wide. Release gives no pulse.
3. Glitch rejection: btn_in[1] pulses high for 2 ticks, then low -> btn_level stays 0000 and pulse_valid never asserts.
4. Simultaneous press: btn_in=1011 from the same cycle -> pulses in consecutive cycles with ids 0, 1, 3 (step_pulse 0001, 0010, 1000). No gaps, no duplicates.
5. Auto-repeat:
   - Hold btn 2 with repeat_en[2]=1 -> initial pulse, repeat pulse 5 ticks after the press, then one pulse every 2 ticks.
   - Clear repeat_en[2] -> pulses stop.
   - Re-enable -> a repeat pulse on the next tick.
   - Release -> FSM returns to IDLE, with no release pulse.
6. Reset mid-operation: assert reset while btn 3 is in REPEAT and pending=1000 -> next cycle all outputs and btn_level are 0. With the button still held after reset, one new press pulse appears after 3 ticks.
